// File: rtl/axi4_lite_master_if_pkg.sv
// Shared AXI4-Lite response codes and master FSM state encodings.
// Imported by the master, the interconnect and the peripherals so that all of them agree on one encoding.
package axi4_lite_master_if_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } r_state_t;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi4_lite_timeout_ctr.sv
// Per-path transaction watchdog: expired is asserted during the LIMIT-th consecutive enabled cycle; LIMIT=0 disables it.
// Latency: combinational expired from a registered count; there is no backpressure.
module axi4_lite_timeout_ctr #(
  parameter int LIMIT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (LIMIT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);
      logic [CW-1:0] r_count;

      // The count tracks completed non-idle cycles, so the LIMIT-th cycle sees LIMIT-1.
      assign expired = enable && (r_count == CW'(LIMIT - 1));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_count <= '0;
        end else if (clear) begin
          r_count <= '0;
        end else if (enable && !expired) begin
          r_count <= r_count + CW'(1);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/axi4_lite_master_if.sv
// Converts MEM-stage start/busy requests into AXI4-Lite traffic, with independent write and read paths that each have a watchdog.
// Latency: 3 cycles from start to busy low when the slave is always ready; starts are ignored while a path is busy.
module axi4_lite_master_if
  import axi4_lite_master_if_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    TIMEOUT_CYCLES = 256,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_RDATA  = 32'hDEADBEEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    write_start,
  input  logic [ADDR_WIDTH-1:0]   write_addr,
  input  logic [DATA_WIDTH-1:0]   write_data,
  input  logic [DATA_WIDTH/8-1:0] write_strobe,
  output logic                    write_busy,
  output logic                    write_error,
  input  logic                    read_start,
  input  logic [ADDR_WIDTH-1:0]   read_addr,
  output logic [DATA_WIDTH-1:0]   read_data,
  output logic                    read_busy,
  output logic                    read_error,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rvalid,
  output logic                    m_rready
);

  w_state_t r_wstate, w_wstate_nxt;
  logic r_awvalid, w_awvalid_nxt, r_wvalid, w_wvalid_nxt, r_bready, w_bready_nxt;
  logic r_write_error, w_write_error_nxt;
  logic [ADDR_WIDTH-1:0]   r_awaddr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH/8-1:0] r_wstrb;
  logic w_wto, w_wr_active, w_aw_done, w_w_done;

  assign w_wr_active = (r_wstate != W_IDLE);
  // A channel counts as done if it already handshook earlier or handshakes this cycle.
  assign w_aw_done   = !r_awvalid || m_awready;
  assign w_w_done    = !r_wvalid || m_wready;

  axi4_lite_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_wr_timeout (
    .clk(clk), .rst(rst), .clear(!w_wr_active), .enable(w_wr_active), .expired(w_wto)
  );

  always_comb begin
    w_wstate_nxt      = r_wstate;
    w_awvalid_nxt     = r_awvalid;
    w_wvalid_nxt      = r_wvalid;
    w_bready_nxt      = r_bready;
    w_write_error_nxt = r_write_error;
    case (r_wstate)
      W_IDLE: if (write_start) begin
        w_wstate_nxt  = W_REQ;
        w_awvalid_nxt = 1'b1;
        w_wvalid_nxt  = 1'b1;
      end
      W_REQ: begin
        if (w_aw_done && w_w_done) begin
          w_wstate_nxt  = W_RESP;
          w_awvalid_nxt = 1'b0;
          w_wvalid_nxt  = 1'b0;
          w_bready_nxt  = 1'b1;
        end else if (w_wto) begin
          w_wstate_nxt      = W_IDLE;
          w_awvalid_nxt     = 1'b0;
          w_wvalid_nxt      = 1'b0;
          w_write_error_nxt = 1'b1;
        end else begin
          if (r_awvalid && m_awready) w_awvalid_nxt = 1'b0;
          if (r_wvalid && m_wready)   w_wvalid_nxt  = 1'b0;
        end
      end
      W_RESP: begin
        if (m_bvalid) begin
          w_wstate_nxt      = W_IDLE;
          w_bready_nxt      = 1'b0;
          w_write_error_nxt = resp_is_err(m_bresp);
        end else if (w_wto) begin
          w_wstate_nxt      = W_IDLE;
          w_bready_nxt      = 1'b0;
          w_write_error_nxt = 1'b1;
        end
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wstate      <= W_IDLE;
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_bready      <= 1'b0;
      r_write_error <= 1'b0;
      r_awaddr      <= '0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
    end else begin
      r_wstate      <= w_wstate_nxt;
      r_awvalid     <= w_awvalid_nxt;
      r_wvalid      <= w_wvalid_nxt;
      r_bready      <= w_bready_nxt;
      r_write_error <= w_write_error_nxt;
      if (!w_wr_active && write_start) begin
        r_awaddr <= write_addr;
        r_wdata  <= write_data;
        r_wstrb  <= write_strobe;
      end
    end
  end

  r_state_t r_rstate, w_rstate_nxt;
  logic r_arvalid, w_arvalid_nxt, r_rready, w_rready_nxt, r_read_error, w_read_error_nxt;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [DATA_WIDTH-1:0] r_read_data, w_read_data_nxt;
  logic w_rto, w_rd_active;

  assign w_rd_active = (r_rstate != R_IDLE);

  axi4_lite_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_rd_timeout (
    .clk(clk), .rst(rst), .clear(!w_rd_active), .enable(w_rd_active), .expired(w_rto)
  );

  always_comb begin
    w_rstate_nxt     = r_rstate;
    w_arvalid_nxt    = r_arvalid;
    w_rready_nxt     = r_rready;
    w_read_error_nxt = r_read_error;
    w_read_data_nxt  = r_read_data;
    case (r_rstate)
      R_IDLE: if (read_start) begin
        w_rstate_nxt  = R_ADDR;
        w_arvalid_nxt = 1'b1;
      end
      R_ADDR: begin
        if (m_arready) begin
          w_rstate_nxt  = R_DATA;
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
        end else if (w_rto) begin
          w_rstate_nxt     = R_IDLE;
          w_arvalid_nxt    = 1'b0;
          w_read_error_nxt = 1'b1;
          w_read_data_nxt  = TIMEOUT_RDATA;
        end
      end
      R_DATA: begin
        if (m_rvalid) begin
          w_rstate_nxt     = R_IDLE;
          w_rready_nxt     = 1'b0;
          w_read_error_nxt = resp_is_err(m_rresp);
          w_read_data_nxt  = m_rdata;
        end else if (w_rto) begin
          w_rstate_nxt     = R_IDLE;
          w_rready_nxt     = 1'b0;
          w_read_error_nxt = 1'b1;
          w_read_data_nxt  = TIMEOUT_RDATA;
        end
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rstate     <= R_IDLE;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_read_error <= 1'b0;
      r_read_data  <= '0;
      r_araddr     <= '0;
    end else begin
      r_rstate     <= w_rstate_nxt;
      r_arvalid    <= w_arvalid_nxt;
      r_rready     <= w_rready_nxt;
      r_read_error <= w_read_error_nxt;
      r_read_data  <= w_read_data_nxt;
      if (!w_rd_active && read_start) r_araddr <= read_addr;
    end
  end

  assign write_busy  = w_wr_active;
  assign write_error = r_write_error;
  assign m_awaddr    = r_awaddr;
  assign m_awvalid   = r_awvalid;
  assign m_wdata     = r_wdata;
  assign m_wstrb     = r_wstrb;
  assign m_wvalid    = r_wvalid;
  assign m_bready    = r_bready;
  assign read_busy   = w_rd_active;
  assign read_error  = r_read_error;
  assign read_data   = r_read_data;
  assign m_araddr    = r_araddr;
  assign m_arvalid   = r_arvalid;
  assign m_rready    = r_rready;

endmodule

// File: tb/tb_axi4_lite_master_if.sv
// Directed bench for axi4_lite_master_if: the bench drives the slave side itself, and a scoreboard holds the expected completions.
module tb_axi4_lite_master_if;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        write_start = 1'b0;
  logic [31:0] write_addr = '0;
  logic [31:0] write_data = '0;
  logic [3:0]  write_strobe = '0;
  logic        write_busy, write_error;
  logic        read_start = 1'b0;
  logic [31:0] read_addr = '0;
  logic [31:0] read_data;
  logic        read_busy, read_error;
  logic [31:0] m_awaddr;
  logic        m_awvalid;
  logic        m_awready = 1'b0;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid;
  logic        m_wready = 1'b0;
  logic [1:0]  m_bresp = 2'b00;
  logic        m_bvalid = 1'b0;
  logic        m_bready;
  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic        m_arready = 1'b0;
  logic [31:0] m_rdata = '0;
  logic [1:0]  m_rresp = 2'b00;
  logic        m_rvalid = 1'b0;
  logic        m_rready;

  always #5 clk = ~clk;

  axi4_lite_master_if #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .write_start(write_start), .write_addr(write_addr), .write_data(write_data),
    .write_strobe(write_strobe), .write_busy(write_busy), .write_error(write_error),
    .read_start(read_start), .read_addr(read_addr), .read_data(read_data),
    .read_busy(read_busy), .read_error(read_error),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
  } rd_exp_t;

  rd_exp_t rd_q[$];
  logic    wr_q[$];
  int      total = 0;
  int      bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic wr_pop(input string tag);
    logic e;
    chk({tag, "_sb"}, 64'(wr_q.size()), 64'd1);
    if (wr_q.size() > 0) begin
      e = wr_q.pop_front();
      chk({tag, "_werr"}, 64'(write_error), 64'(e));
    end
  endtask

  task automatic rd_pop(input string tag);
    rd_exp_t e;
    chk({tag, "_sb"}, 64'(rd_q.size()), 64'd1);
    if (rd_q.size() > 0) begin
      e = rd_q.pop_front();
      chk({tag, "_rdata"}, 64'(read_data), 64'(e.data));
      chk({tag, "_rerr"}, 64'(read_error), 64'(e.err));
    end
  endtask

  // Issue one read with the slave ready on AR and R arriving after 'waits' idle cycles.
  task automatic rd_txn(input string tag, input logic [31:0] addr, input logic [31:0] data,
                        input logic [1:0] resp, input int waits);
    read_start = 1'b1;
    read_addr  = addr;
    m_arready  = 1'b1;
    rd_q.push_back('{data, (resp != 2'b00)});
    tick;
    read_start = 1'b0;
    chk({tag, "_arvalid"}, 64'(m_arvalid), 64'd1);
    chk({tag, "_araddr"}, 64'(m_araddr), 64'(addr));
    tick;
    chk({tag, "_rready"}, 64'(m_rready), 64'd1);
    repeat (waits) tick;
    chk({tag, "_busy_wait"}, 64'(read_busy), 64'd1);
    m_rvalid = 1'b1;
    m_rdata  = data;
    m_rresp  = resp;
    tick;
    m_rvalid = 1'b0;
    chk({tag, "_busy_done"}, 64'(read_busy), 64'd0);
    chk({tag, "_rready_done"}, 64'(m_rready), 64'd0);
    rd_pop(tag);
  endtask

  initial begin
    int n;

    // Reset state
    repeat (2) tick;
    chk("rst_valids", 64'({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}), 64'd0);
    chk("rst_busy_err", 64'({write_busy, read_busy, write_error, read_error}), 64'd0);
    chk("rst_rdata", 64'(read_data), 64'd0);
    rst = 1'b0;
    tick;

    // 1: back-to-back ready slave, AW and W in one cycle
    write_start = 1'b1; write_addr = 32'h4000_0000; write_data = 32'h0000_0001; write_strobe = 4'hF;
    m_awready = 1'b1; m_wready = 1'b1;
    wr_q.push_back(1'b0);
    tick;
    write_start = 1'b0;
    chk("t1_aw_w_valid", 64'({m_awvalid, m_wvalid}), 64'd3);
    chk("t1_busy", 64'(write_busy), 64'd1);
    chk("t1_beat", {m_awaddr, m_wdata}, 64'h4000_0000_0000_0001);
    chk("t1_strb", 64'(m_wstrb), 64'hF);
    tick;
    chk("t1_after_hs", 64'({m_awvalid, m_wvalid, m_bready}), 64'd1);
    m_bvalid = 1'b1; m_bresp = 2'b00;
    tick;
    m_bvalid = 1'b0;
    chk("t1_busy_low", 64'(write_busy), 64'd0);
    wr_pop("t1");

    // 2: AWREADY late by 4 cycles, W accepted at once, SLVERR response
    write_start = 1'b1; write_addr = 32'h4000_0008; write_data = 32'h1234_5678; write_strobe = 4'h3;
    m_awready = 1'b0; m_wready = 1'b1;
    wr_q.push_back(1'b1);
    for (int i = 1; i <= 4; i++) begin
      tick;
      write_start = 1'b0;
      chk("t2_awvalid_held", 64'(m_awvalid), 64'd1);
      chk("t2_wvalid", 64'(m_wvalid), 64'(i == 1));
      if (i == 2) begin
        write_start = 1'b1;
        write_addr  = 32'h5000_0000;
      end
      if (i == 3) chk("t2_ignored_start", 64'(m_awaddr), 64'h4000_0008);
      if (i == 4) m_awready = 1'b1;
    end
    tick;
    m_awready = 1'b0;
    chk("t2_resp_phase", 64'({m_awvalid, m_bready, write_busy}), 64'd3);
    m_bvalid = 1'b1; m_bresp = 2'b10;
    tick;
    chk("t2_bready_drop", 64'({m_bready, write_busy}), 64'd0);
    wr_pop("t2");
    tick;
    m_bvalid = 1'b0;
    chk("t2_single_b", 64'({m_bready, write_busy}), 64'd0);

    // 3 and 4: reads with waits, a DECERR, then an OKAY that clears the error
    rd_txn("t3", 32'h4000_0004, 32'hA5A5_5A5A, 2'b00, 2);
    rd_txn("t4a", 32'h4000_000C, 32'h0BAD_F00D, 2'b11, 0);
    tick;
    chk("t4_err_persist", 64'(read_error), 64'd1);
    rd_txn("t4b", 32'h4000_0010, 32'h1111_2222, 2'b00, 1);

    // 5: slave never answers AR; the watchdog aborts after 8 cycles
    read_start = 1'b1; read_addr = 32'h4000_0020; m_arready = 1'b0;
    rd_q.push_back('{32'hDEADBEEF, 1'b1});
    tick;
    read_start = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && m_arvalid; i++) begin
      n++;
      tick;
    end
    chk("t5_arvalid_cycles", 64'(n), 64'd8);
    chk("t5_busy", 64'(read_busy), 64'd0);
    rd_pop("t5");

    // 6: concurrent write and read, then reset while waiting for B
    chk("t6_werr_persist", 64'(write_error), 64'd1);
    write_start = 1'b1; write_addr = 32'h4000_0030; write_data = 32'hCAFE_0001; write_strobe = 4'hF;
    read_start  = 1'b1; read_addr  = 32'h4000_0034;
    m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
    tick;
    write_start = 1'b0; read_start = 1'b0;
    chk("t6_both_busy", 64'({write_busy, read_busy}), 64'd3);
    chk("t6_both_addr_valid", 64'({m_awvalid, m_arvalid}), 64'd3);
    tick;
    chk("t6_resp_phase", 64'({m_bready, m_rready, write_busy, read_busy}), 64'hF);
    rst = 1'b1;
    #1;
    chk("t6_rst_valids", 64'({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}), 64'd0);
    chk("t6_rst_flags", 64'({write_busy, read_busy, write_error, read_error}), 64'd0);
    chk("t6_rst_rdata", 64'(read_data), 64'd0);
    chk("t6_rst_awaddr", 64'(m_awaddr), 64'd0);
    tick;
    rst = 1'b0;
    m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
    tick;
    chk("t6_post_rst_idle", 64'({write_busy, read_busy, m_awvalid, m_arvalid}), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
